// File: rtl/dd_pkg.sv
// Shared types and constants for the DoubleDabble BCD path and its ASCII streamer.
package dd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, SEND, TERM, FIN} streamer_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Invalid BCD digits (> 9) render as '?'.
  function automatic logic [7:0] digit_to_ascii(input bcd_digit_t d);
    return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
  endfunction

endpackage

// File: rtl/leading_digit_finder.sv
// Priority encoder: index of the most significant non-zero BCD digit, 0 when all digits are zero.
module leading_digit_finder
  import dd_pkg::*;
#(
  parameter int unsigned D  = 10,
  parameter int unsigned IW = (D > 1) ? $clog2(D) : 1
) (
  input  bcd_digit_t [D-1:0] i_digits,
  output logic [IW-1:0]      o_idx
);

  // Ascending scan so the highest non-zero position wins.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < D; i++) begin
      if (i_digits[i] != 4'h0) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/bcd_ascii_streamer.sv
// Captures a packed BCD result and streams it as leading-zero-suppressed ASCII decimal plus EOL
// over a valid/accept handshake.
module bcd_ascii_streamer
  import dd_pkg::*;
#(
  parameter int unsigned D   = 10,
  parameter logic [7:0]  EOL = 8'h0A
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  bcd_digit_t [D-1:0] i_bcd,
  output logic [7:0]         o_char,
  output logic               o_valid,
  input  logic               i_accept,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

  streamer_state_t    r_state;
  bcd_digit_t [D-1:0] r_digits;
  logic [IW-1:0]      r_idx;
  logic [7:0]         r_char;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic [IW-1:0]      w_lead;
  logic [IW-1:0]      w_idx_dec;
  logic               w_bad;

  leading_digit_finder #(
    .D  (D),
    .IW (IW)
  ) u_finder (
    .i_digits (i_bcd),
    .o_idx    (w_lead)
  );

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (i_bcd[i] > 4'd9) w_bad = 1'b1;
    end
  end

  assign w_idx_dec = r_idx - 1'b1;

  // Next character is computed ahead of the accept so Char stays a pure register output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_digits <= '0;
      r_idx    <= '0;
      r_char   <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_load) begin
            r_digits <= i_bcd;
            r_idx    <= w_lead;
            r_error  <= w_bad;
            r_char   <= digit_to_ascii(i_bcd[w_lead]);
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= SEND;
          end
        end
        SEND: begin
          if (i_accept) begin
            if (r_idx == '0) begin
              r_char  <= EOL;
              r_state <= TERM;
            end else begin
              r_idx  <= w_idx_dec;
              r_char <= digit_to_ascii(r_digits[w_idx_dec]);
            end
          end
        end
        TERM: begin
          if (i_accept) begin
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_char  = r_char;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Self-checking bench: table-driven streams plus hand sequences, accepted chars checked by scoreboard.
module tb_bcd_ascii_streamer;
  import dd_pkg::*;

  typedef struct {
    logic [39:0]     bcd;
    longint unsigned v;
    string           alt;
    bit              err;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [39:0]        bcd;
  bcd_digit_t [9:0]   bcd_p;
  logic [7:0]         o_char;
  logic               o_valid;
  logic               accept;
  logic               o_busy;
  logic               o_done;
  logic               o_error;

  int                 checks = 0;
  int                 errors = 0;
  int                 done_cnt = 0;
  logic [7:0]         sb[$];
  bit                 prev_stall = 1'b0;
  logic [7:0]         prev_char = 8'h00;
  bit                 pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  vec_t               vecs[7];

  assign bcd_p = bcd;

  always #5 clk = ~clk;

  bcd_ascii_streamer #(
    .D   (10),
    .EOL (8'h0A)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (load),
    .i_bcd    (bcd_p),
    .o_char   (o_char),
    .o_valid  (o_valid),
    .i_accept (accept),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake stability and accepted-character scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", {63'd0, o_valid}, 64'd1);
        check("hold_char", {56'd0, o_char}, {56'd0, prev_char});
      end
      if (o_valid && accept) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0h, required no character", o_char);
        end else begin
          check("char", {56'd0, o_char}, {56'd0, sb.pop_front()});
        end
      end
      prev_stall = o_valid && !accept;
      prev_char  = o_char;
    end
  end

  task automatic wait_done(input string name, output bit fin);
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk);
      #1;
      if (o_done) fin = 1'b1;
    end
    check(name, {63'd0, fin}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int mode);
    string s;
    int    busy_cycles;
    int    d0;
    bit    fin;
    s = (v.alt.len() == 0) ? $sformatf("%0d\n", v.v) : v.alt;
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    d0   = done_cnt;
    bcd  = v.bcd;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("busy_after_load", {63'd0, o_busy}, 64'd1);
    check("error_after_load", {63'd0, o_error}, {63'd0, v.err});
    busy_cycles = 0;
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      case (mode)
        0:       accept = 1'b1;
        1:       accept = 1'($urandom_range(0, 1));
        default: accept = (k < 6) ? pat[k] : 1'b1;
      endcase
      if (o_busy) busy_cycles++;
      @(posedge clk);
      #1;
      if (o_done) fin = 1'b1;
    end
    check("done_seen", {63'd0, fin}, 64'd1);
    if (mode == 0) check("busy_cycles", 64'(busy_cycles), 64'(s.len()));
    accept = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("error_sticky", {63'd0, o_error}, {63'd0, v.err});
    check("idle_valid", {63'd0, o_valid}, 64'd0);
  endtask

  initial begin
    bit fin;
    int d0;
    string s;

    vecs[0] = '{40'h1234567890, 64'd1234567890, "", 1'b0};
    vecs[1] = '{40'h0000000042, 64'd42, "", 1'b0};
    vecs[2] = '{40'h0000000000, 64'd0, "", 1'b0};
    vecs[3] = '{40'h00000001A5, 64'd0, "1?5\n", 1'b1};
    vecs[4] = '{40'h0000000907, 64'd907, "", 1'b0};
    vecs[5] = '{40'h0000000007, 64'd7, "", 1'b0};
    vecs[6] = '{40'h9000000001, 64'd9000000001, "", 1'b0};

    rst = 1'b1; load = 1'b0; accept = 1'b1; bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_char", {56'd0, o_char}, 64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_error", {63'd0, o_error}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0);
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1);
    run_vec(vecs[4], 2);

    // Loads while busy and during FIN are dropped; the next IDLE load is taken.
    s = "1234567890\n";
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    d0 = done_cnt;
    bcd = 40'h1234567890; load = 1'b1; accept = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #1 bcd = 40'h99; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_done("done_seen_busy_load", fin);
    bcd = 40'h55; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("fin_load_busy", {63'd0, o_busy}, 64'd0);
    check("fin_load_valid", {63'd0, o_valid}, 64'd0);
    sb.push_back(8'h38);
    sb.push_back(8'h0A);
    bcd = 40'h8; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    check("post_fin_load_busy", {63'd0, o_busy}, 64'd1);
    wait_done("done_seen_post_fin", fin);
    repeat (2) @(posedge clk);
    #1;
    check("drop_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Reset mid-stream after three accepted characters, together with a Load.
    s = "123";
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    d0 = done_cnt;
    bcd = 40'h1234567890; load = 1'b1; accept = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; load = 1'b1; bcd = 40'h77;
    @(posedge clk);
    #1;
    check("abort_valid", {63'd0, o_valid}, 64'd0);
    check("abort_busy", {63'd0, o_busy}, 64'd0);
    check("abort_char", {56'd0, o_char}, 64'd0);
    check("abort_done", {63'd0, o_done}, 64'd0);
    load = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_idle_busy", {63'd0, o_busy}, 64'd0);
    check("abort_idle_valid", {63'd0, o_valid}, 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_sb_drained", 64'(sb.size()), 64'd0);

    run_vec(vecs[1], 0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
